bf_host_port: RTL
=================

# bf_host_port

Host-side peer of `bf_machine`'s I/O streams. It buffers words from a host producer into the machine's `machine_input` channel and buffers `machine_output` words for a host consumer, using valid/ready on all four channels. An optional end-of-input timeout injects a fixed EOF word when the machine waits on an empty input buffer. It sits between `bf_machine` and the host/testbench/UART-side logic.

## Interface
- `WORD_SIZE`, 8: width of every data word.
- `IN_DEPTH`, 4: input FIFO entries; power of two, at least 2.
- `OUT_DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `EOF_TIMEOUT`, 0: number of starved cycles before EOF injection; 0 disables injection.
- `EOF_VALUE`, 0: word injected on timeout.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous assert, active-low; deasserts synchronously to `clk` externally.
- `host_wr_data` in WORD_SIZE: word from the host producer.
- `host_wr_valid` in 1: host offers `host_wr_data`.
- `host_wr_ready` out 1: input FIFO not full.
- `host_rd_data` out WORD_SIZE: head of the output FIFO.
- `host_rd_valid` out 1: output FIFO not empty.
- `host_rd_ready` in 1: host takes the head word.
- `machine_input` out WORD_SIZE: word to the machine.
- `machine_input_valid` out 1: `machine_input` is valid.
- `machine_input_ready` in 1: machine accepts.
- `machine_output` in WORD_SIZE: word from the machine.
- `machine_output_valid` in 1: machine offers a word.
- `machine_output_ready` out 1: output FIFO not full.
- `in_level` out $clog2(IN_DEPTH)+1: input FIFO occupancy.
- `out_level` out $clog2(OUT_DEPTH)+1: output FIFO occupancy.
- `eof_sent` out 1: sticky flag; set when an EOF word transfers.

## Operation
- Transfer rule: on any channel, a word moves on a rising edge where valid and ready are both 1.
- Input FIFO:
  - Pushed by host transfers.
  - Popped by machine transfers of FIFO data; injected words do not pop it.
  - The FIFO is first-word-fall-through, so `machine_input` equals the head entry when `machine_input_valid` is 1.
- Output FIFO:
  - Pushed by machine transfers.
  - Popped by host transfers.
  - `host_rd_data` equals the head entry.
- Ready signals depend only on the current level, never on the same-cycle pop.
  - `host_wr_ready = (in_level != IN_DEPTH)`.
  - `machine_output_ready = (out_level != OUT_DEPTH)`.
  - A write to a full FIFO is refused even if a pop happens in the same cycle.
- Pointers wrap modulo depth. When a FIFO is neither full nor empty, a push and a pop in the same cycle leave the level unchanged.
- Valid stability: once `machine_input_valid` is 1, the valid and `machine_input` hold until a transfer.
- The EOF FSM has three states: IDLE, WAIT and INJECT. It is used only when `EOF_TIMEOUT > 0`.
  - IDLE -> WAIT when `machine_input_ready` is 1 and the input FIFO is empty. The starve counter loads 1.
  - WAIT:
    - The counter increments on each cycle where `machine_input_ready` is 1 and the FIFO is empty.
    - Go to IDLE if the FIFO becomes non-empty or `machine_input_ready` drops. The counter clears.
    - Go to INJECT when the counter reaches `EOF_TIMEOUT` and the FIFO is still empty.
  - INJECT:
    - Drive `machine_input = EOF_VALUE` with `machine_input_valid = 1`.
    - Host pushes in this state are stored, but the injected word holds until it transfers.
    - On transfer: set `eof_sent` and go to IDLE. Any FIFO data is presented from the next cycle.
- Real data always takes priority: an EOF word is never presented while the FIFO is non-empty, except when the injection is already committed in INJECT.
- Status outputs `in_level` and `out_level` are registered and reflect the state after the last edge.

## Timing
- Reset values:
  - FIFOs empty; EOF FSM in IDLE; counter 0.
  - `machine_input_valid`, `host_rd_valid` and `eof_sent` are 0.
  - `machine_input` and `host_rd_data` are 0.
  - `in_level` and `out_level` are 0.
  - `host_wr_ready` and `machine_output_ready` are 1.
- Reset mid-operation: asserting `rst` immediately forces all of the reset values above, including dropping any valid; buffered words are discarded.
- Latency:
  - A host push at edge N makes the word visible on `machine_input` with valid after edge N. The first transfer can occur at edge N+1.
  - The output path has the same one-cycle latency, from machine push to `host_rd_valid`.
- Throughput: one word per cycle per direction, sustained while neither FIFO is full or empty.
- EOF timing: with T = `EOF_TIMEOUT`, injection becomes valid after T consecutive starved edges.

## Test plan
- Basic pass-through: host writes 3, 9, 5 with a 2-cycle ready stall on the machine side -> the machine receives 3, 9, 5 in order, valid holds through the stall, and `in_level` returns to 0.
- Output backpressure with `OUT_DEPTH = 4`: the machine emits 1..6 while `host_rd_ready = 0` -> `machine_output_ready` drops after 4 words and `out_level = 4`. Then the host drains -> 1..6 arrive in order with nothing lost or duplicated.
- Full with simultaneous pop: input FIFO full, host valid and machine pops in the same cycle -> the host word is refused, the level goes 4 -> 3, and the host word is accepted on the next edge.
- EOF injection with `EOF_TIMEOUT = 5`, `EOF_VALUE = 0xFF`: the machine is ready on an empty FIFO -> 0xFF is offered after 5 cycles and `eof_sent = 1` after the transfer. A host write of 7 at cycle 3 of the same wait instead cancels the injection, 7 transfers, and `eof_sent` stays 0.
- Write during INJECT: the host pushes 4 while 0xFF is offered and the machine is stalled -> 0xFF transfers first, then 4, with `in_level` going 1 -> 0.
- Reset mid-stream: assert `rst` with 2 words buffered in each FIFO -> both valids go to 0 and both levels go to 0 immediately. After release, host writes 8 -> the machine receives only 8.

Source files
------------

// File: rtl/bf_host_port.sv
// bf_host_port: host-side peer of bf_machine's I/O streams.
// Buffers host words into the machine input channel and machine output words
// toward the host, both through first-word-fall-through FIFOs. When
// EOF_TIMEOUT > 0, a machine that keeps waiting on an empty input buffer for
// EOF_TIMEOUT consecutive cycles is offered a single EOF_VALUE word.
// Ports:
//   clk, rst                       clock and asynchronous active-low reset
//   host_wr_data/valid/ready       host producer -> input FIFO
//   host_rd_data/valid/ready       output FIFO -> host consumer
//   machine_input/_valid/_ready    input FIFO (or EOF word) -> machine
//   machine_output/_valid/_ready   machine -> output FIFO
//   in_level, out_level            FIFO occupancy
//   eof_sent                       sticky, set once an EOF word transfers
module bf_host_port #(
  parameter int                   WORD_SIZE   = 8,
  parameter int                   IN_DEPTH    = 4,
  parameter int                   OUT_DEPTH   = 4,
  parameter int                   EOF_TIMEOUT = 0,
  parameter logic [WORD_SIZE-1:0] EOF_VALUE   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WORD_SIZE-1:0]         host_wr_data,
  input  logic                         host_wr_valid,
  output logic                         host_wr_ready,
  output logic [WORD_SIZE-1:0]         host_rd_data,
  output logic                         host_rd_valid,
  input  logic                         host_rd_ready,
  output logic [WORD_SIZE-1:0]         machine_input,
  output logic                         machine_input_valid,
  input  logic                         machine_input_ready,
  input  logic [WORD_SIZE-1:0]         machine_output,
  input  logic                         machine_output_valid,
  output logic                         machine_output_ready,
  output logic [$clog2(IN_DEPTH):0]    in_level,
  output logic [$clog2(OUT_DEPTH):0]   out_level,
  output logic                         eof_sent
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int CW  = $clog2(EOF_TIMEOUT + 1) + 1;
  localparam logic [IAW:0]  IN_FULL_LVL  = (IAW + 1)'(IN_DEPTH);
  localparam logic [OAW:0]  OUT_FULL_LVL = (OAW + 1)'(OUT_DEPTH);
  localparam logic [CW-1:0] CNT_LAST     = CW'((EOF_TIMEOUT > 0) ? (EOF_TIMEOUT - 1) : 0);
  localparam bit            EOF_EN       = (EOF_TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_INJECT = 2'd2
  } eof_state_t;

  logic [WORD_SIZE-1:0] in_mem_r  [IN_DEPTH];
  logic [IAW-1:0]       in_rd_ptr_r, in_wr_ptr_r;
  logic [IAW:0]         in_cnt_r;
  logic [WORD_SIZE-1:0] out_mem_r [OUT_DEPTH];
  logic [OAW-1:0]       out_rd_ptr_r, out_wr_ptr_r;
  logic [OAW:0]         out_cnt_r;
  eof_state_t           state_r;
  logic [CW-1:0]        starve_cnt_r;
  logic                 eof_sent_r;

  logic in_empty_s, in_full_s, in_push_s, in_pop_s;
  logic out_empty_s, out_full_s, out_push_s, out_pop_s;
  logic inject_s, starved_s;

  assign in_empty_s  = (in_cnt_r == '0);
  assign in_full_s   = (in_cnt_r == IN_FULL_LVL);
  assign out_empty_s = (out_cnt_r == '0);
  assign out_full_s  = (out_cnt_r == OUT_FULL_LVL);
  assign inject_s    = (state_r == ST_INJECT);

  // Readiness looks only at the current level, so a full FIFO refuses a
  // write even in a cycle where it is also popped.
  assign in_push_s  = host_wr_valid & ~in_full_s;
  assign in_pop_s   = machine_input_ready & ~inject_s & ~in_empty_s;
  assign out_push_s = machine_output_valid & ~out_full_s;
  assign out_pop_s  = host_rd_ready & ~out_empty_s;

  // A cycle counts as starved only if the FIFO stays empty across the edge;
  // a same-cycle host push already means real data is on its way.
  assign starved_s = machine_input_ready & in_empty_s & ~in_push_s;

  assign host_wr_ready        = ~in_full_s;
  assign machine_output_ready = ~out_full_s;
  assign machine_input_valid  = inject_s | ~in_empty_s;
  assign host_rd_valid        = ~out_empty_s;
  assign in_level             = in_cnt_r;
  assign out_level            = out_cnt_r;
  assign eof_sent             = eof_sent_r;

  // Word presented to the machine: committed EOF first, else FIFO head.
  always_comb begin
    if (inject_s) begin
      machine_input = EOF_VALUE;
    end else if (!in_empty_s) begin
      machine_input = in_mem_r[in_rd_ptr_r];
    end else begin
      machine_input = '0;
    end
  end

  // Word presented to the host: output FIFO head, zero when empty.
  always_comb begin
    if (!out_empty_s) begin
      host_rd_data = out_mem_r[out_rd_ptr_r];
    end else begin
      host_rd_data = '0;
    end
  end

  // Input FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IN_DEPTH; i++) in_mem_r[i] <= '0;
      in_rd_ptr_r <= '0;
      in_wr_ptr_r <= '0;
      in_cnt_r    <= '0;
    end else begin
      if (in_push_s) begin
        in_mem_r[in_wr_ptr_r] <= host_wr_data;
        in_wr_ptr_r           <= in_wr_ptr_r + IAW'(1);
      end
      if (in_pop_s) begin
        in_rd_ptr_r <= in_rd_ptr_r + IAW'(1);
      end
      case ({in_push_s, in_pop_s})
        2'b10:   in_cnt_r <= in_cnt_r + (IAW + 1)'(1);
        2'b01:   in_cnt_r <= in_cnt_r - (IAW + 1)'(1);
        default: in_cnt_r <= in_cnt_r;
      endcase
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OUT_DEPTH; i++) out_mem_r[i] <= '0;
      out_rd_ptr_r <= '0;
      out_wr_ptr_r <= '0;
      out_cnt_r    <= '0;
    end else begin
      if (out_push_s) begin
        out_mem_r[out_wr_ptr_r] <= machine_output;
        out_wr_ptr_r            <= out_wr_ptr_r + OAW'(1);
      end
      if (out_pop_s) begin
        out_rd_ptr_r <= out_rd_ptr_r + OAW'(1);
      end
      case ({out_push_s, out_pop_s})
        2'b10:   out_cnt_r <= out_cnt_r + (OAW + 1)'(1);
        2'b01:   out_cnt_r <= out_cnt_r - (OAW + 1)'(1);
        default: out_cnt_r <= out_cnt_r;
      endcase
    end
  end

  // EOF timeout FSM: count consecutive starved cycles, then commit to EOF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= '0;
      eof_sent_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (EOF_EN && starved_s) begin
            if (EOF_TIMEOUT == 1) begin
              state_r      <= ST_INJECT;
              starve_cnt_r <= '0;
            end else begin
              state_r      <= ST_WAIT;
              starve_cnt_r <= CW'(1);
            end
          end else begin
            starve_cnt_r <= '0;
          end
        end
        ST_WAIT: begin
          if (!starved_s) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= '0;
          end else if (starve_cnt_r == CNT_LAST) begin
            state_r      <= ST_INJECT;
            starve_cnt_r <= '0;
          end else begin
            starve_cnt_r <= starve_cnt_r + CW'(1);
          end
        end
        ST_INJECT: begin
          // Held until taken, even if host data arrives meanwhile.
          if (machine_input_ready) begin
            eof_sent_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            state_r    <= ST_INJECT;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          starve_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
